line_column_buffer: RTL

- Upstream feeder for the convolution sliding-window stage.
- Accepts a raster-order pixel stream (one pixel per beat, valid/ready) and stores the previous KERNEL_HEIGHT-1 image rows in line memories.
- For each accepted pixel, emits one vertical column of KERNEL_HEIGHT pixels at that x position. The column is packed in the exact format the window stage consumes on its column input.
- Suppresses output until enough rows are buffered; re-primes at every frame boundary.

---
 rtl/line_column_buffer.sv | 115 +++++++++++
 1 files changed

// File: rtl/line_column_buffer.sv
// Raster-to-column converter: buffers the previous KERNEL_HEIGHT-1 rows and emits
// one vertical KERNEL_HEIGHT-pixel column per accepted pixel once enough rows exist.
module line_column_buffer #(
  parameter int DATA_WIDTH    = 16,
  parameter int KERNEL_HEIGHT = 3,
  parameter int IMG_WIDTH     = 28,
  parameter int IMG_HEIGHT    = 28,
  localparam int XW = $clog2(IMG_WIDTH),
  localparam int YW = $clog2(IMG_HEIGHT)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_WIDTH-1:0]               in_data,
  output logic                                col_valid,
  input  logic                                col_ready,
  output logic [KERNEL_HEIGHT*DATA_WIDTH-1:0] col_data,
  output logic [XW-1:0]                       col_x,
  output logic                                col_eol,
  output logic                                col_eof
);

  // state  | meaning
  // FILL   | priming line memories, y < KERNEL_HEIGHT-1, no output
  // STREAM | every accepted pixel produces a column
  typedef enum logic {FILL, STREAM} state_t;

  localparam logic [XW-1:0] X_LAST      = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_FILL_LAST = YW'(KERNEL_HEIGHT - 2);
  localparam logic [YW-1:0] Y_LAST      = YW'(IMG_HEIGHT - 1);

  state_t state, state_next;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          accept;
  logic [KERNEL_HEIGHT*DATA_WIDTH-1:0] col_next;

  logic [DATA_WIDTH-1:0] line_mem [KERNEL_HEIGHT-1][IMG_WIDTH];

  assign accept = in_valid && in_ready;

  always_comb begin
    state_next = state;
    in_ready   = 1'b1;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (accept && x == X_LAST && y == Y_FILL_LAST)
          state_next = STREAM;
      end
      STREAM: begin
        in_ready = !col_valid || col_ready;
        if (accept && x == X_LAST && y == Y_LAST)
          state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FILL;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Oldest row sits in slice 0; the live pixel fills the top slice.
  always_comb begin
    col_next = '0;
    for (int i = 0; i < KERNEL_HEIGHT - 1; i++)
      col_next[i*DATA_WIDTH +: DATA_WIDTH] = line_mem[i][x];
    col_next[(KERNEL_HEIGHT-1)*DATA_WIDTH +: DATA_WIDTH] = in_data;
  end

  // Line memories are never reset; output gating by state makes stale contents harmless.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < KERNEL_HEIGHT - 2; k++)
        line_mem[k][x] <= line_mem[k+1][x];
      line_mem[KERNEL_HEIGHT-2][x] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_valid <= 1'b0;
      col_data  <= '0;
      col_x     <= '0;
      col_eol   <= 1'b0;
      col_eof   <= 1'b0;
    end else if (accept && state == STREAM) begin
      col_valid <= 1'b1;
      col_data  <= col_next;
      col_x     <= x;
      col_eol   <= (x == X_LAST);
      col_eof   <= (x == X_LAST) && (y == Y_LAST);
    end else if (col_ready) begin
      col_valid <= 1'b0;
    end
  end

endmodule
